transpad_spad_port: RTL
=======================

# transpad_spad_port

Downstream stage of the transpad address-matching datapath. It consumes each host memory access together with the datapath's per-beat hit flag (`spm`) and 24-bit scratchpad address (`out`). Each access is queued in a small in-order FIFO. Hits are served from a single-port scratchpad SRAM; misses are forwarded to main memory over a req/ack handshake. One in-order response is returned per accepted access.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and at least 2.
- `SPAD_AW`, default 12: SRAM address width; the low `SPAD_AW` bits of `spad_addr` are used.
- `DATA_W`, default 32: data width.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req` in 1: host access valid; same cycle as the datapath's `rdy`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 48: host address, used on the miss path.
- `req_wdata` in `DATA_W`: write data.
- `spm` in 1: scratchpad hit, sampled with `req`.
- `spad_addr` in 24: scratchpad address, sampled with `req`.
- `req_ready` out 1: FIFO not full.
- `level` out clog2(`DEPTH`)+1: FIFO occupancy.
- `rsp_valid` out 1: one-cycle response pulse; there is no backpressure.
- `rsp_rdata` out `DATA_W`: read data; 0 for writes.
- `rsp_hit` out 1: the response came from the SRAM.
- `sram_en`, `sram_we` out 1: SRAM strobe; read latency is 1 cycle.
- `sram_addr` out `SPAD_AW`, `sram_wdata` out `DATA_W`.
- `sram_rdata` in `DATA_W`.
- `mem_req`, `mem_we` out 1: main-memory request.
- `mem_addr` out 48, `mem_wdata` out `DATA_W`.
- `mem_ack` in 1, `mem_rdata` in `DATA_W`.

## Operation
- **Enqueue:** on an edge where `req && req_ready`, push {`spm`, `req_we`, `req_addr`, `spad_addr[SPAD_AW-1:0]`, `req_wdata`}. A `req` while `req_ready`=0 is ignored.
- **FIFO pointers and level:** read/write pointers are clog2(`DEPTH`)+1 bits and wrap naturally. Full = MSBs differ and the rest are equal. `level` = wr−rd.
- **`req_ready` when full:** `req_ready` is low whenever full, even if a pop occurs in the same cycle (no bypass).
- **FSM state IDLE, FIFO empty:** stay in IDLE.
- **FSM state IDLE, head hit, write:** `sram_en`=`sram_we`=1 combinationally. At the edge: pop, load `rsp_valid`=1, `rsp_rdata`=0, `rsp_hit`=1, stay IDLE.
- **FSM state IDLE, head hit, read:** `sram_en`=1, `sram_we`=0. At the edge: pop, go to SRAM_RD.
- **FSM state IDLE, head miss:** go to MEM_WAIT; no pop yet.
- **FSM state SRAM_RD:** at the edge, load `rsp_valid`=1, `rsp_rdata`=`sram_rdata`, `rsp_hit`=1, go to IDLE. No SRAM strobe is issued in this state.
- **FSM state MEM_WAIT:** `mem_req`=1 combinationally; `mem_we`, `mem_addr`, `mem_wdata` come from the head and are held stable. On an edge with `mem_ack`=1: pop, load `rsp_valid`=1, `rsp_rdata` = (`mem_we` ? 0 : `mem_rdata`), `rsp_hit`=0, go to IDLE.
- **Pop with simultaneous push:** both pointers advance and `level` is unchanged.
- **Idle outputs:** SRAM/mem output address and data fields carry the head entry whenever their strobe is low; their values are don't-care.
- **Reset (any time, including mid-transaction):** pointers=0, `level`=0, state IDLE. `rsp_valid`=0, `rsp_rdata`=0, `rsp_hit`=0. `mem_req`, `sram_en` and `sram_we` go to 0 immediately. A pending memory transaction is abandoned; a late `mem_ack` after reset is ignored.

## Timing
- **Hit write:** accepted at edge k. SRAM written at edge k+1; `rsp_valid` high in cycle k+1..k+2.
- **Hit read:** accepted at edge k. `sram_en` in cycle k..k+1; `rsp_valid` with data in cycle k+2..k+3.
- **Miss:** accepted at edge k. `mem_req` rises after edge k+1. If `mem_ack` is seen at edge m, `rsp_valid` is high in cycle m..m+1. Minimum miss latency is 2 edges (ack in the first `mem_req` cycle).
- **Throughput:** back-to-back hit writes, 1 per cycle; hit reads, 1 per 2 cycles.
- **Ordering:** responses leave in strict acceptance order. `rsp_valid` is never high two cycles in a row for reads.
- **Registered outputs:** `rsp_*` are registered. `req_ready` and `level` reflect the registered pointers.

## Test plan
- **Reset values:** assert `rst` -> `req_ready`=1, `level`=0, `rsp_valid`=0, `mem_req`=0, `sram_en`=0.
- **Hit write then read:** write hit `spad_addr`=0x000123, data 0xDEADBEEF, then read the same address -> `sram_addr`=0x123 on both. Write response 1 cycle after the write's SRAM strobe. Read returns `rsp_rdata`=0xDEADBEEF, `rsp_hit`=1, 2 edges after acceptance.
- **Miss with delayed ack:** read miss at `req_addr`=0x0000_1000_0040, `mem_ack` after 3 cycles, `mem_rdata`=0x55AA -> `mem_addr` stable across all 3 cycles. One `rsp_valid` with 0x55AA, `rsp_hit`=0.
- **Full FIFO:** stall `mem_ack`, push 5 misses with `DEPTH`=4 -> `level`=4, `req_ready`=0, 5th ignored. Acking 4 times yields 4 in-order responses and `level`=0.
- **Mixed ordering:** sequence miss, hit-read, hit-write with ack delay 2 -> responses in that order. The hit accesses wait behind the miss; no SRAM strobe occurs before the miss response.
- **Reset mid-MEM_WAIT:** assert `rst` while `mem_req`=1 with 2 entries queued -> `mem_req` drops the same cycle, `level`=0. A following `mem_ack` pulse produces no `rsp_valid`.

Source files
------------

// File: rtl/transpad_spad_port.sv
// Serves queued host accesses from the scratchpad SRAM on a hit or from main memory on a miss,
// returning one registered response per accepted access in acceptance order.
module transpad_spad_port #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned SPAD_AW = 12,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     req_we,
    input  logic [47:0]              req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic                     spm,
    input  logic [23:0]              spad_addr,
    output logic                     req_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_hit,
    output logic                     sram_en,
    output logic                     sram_we,
    output logic [SPAD_AW-1:0]       sram_addr,
    output logic [DATA_W-1:0]        sram_wdata,
    input  logic [DATA_W-1:0]        sram_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [47:0]              mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef struct packed {
        logic               spm;
        logic               we;
        logic [47:0]        addr;
        logic [SPAD_AW-1:0] saddr;
        logic [DATA_W-1:0]  wdata;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StSramRd, StMemWait} state_e;

    entry_t      fifo_q [DEPTH];
    entry_t      head;
    logic [PW:0] wr_q, rd_q;
    logic        full, empty, push, pop;

    state_e      state_q, state_d;
    logic        rsp_load;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic        rsp_hit_d;
    logic        rsp_valid_q, rsp_hit_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    // Only the low SPAD_AW bits address the SRAM; the rest are dropped.
    logic [23:0] unused_spad_addr;
    assign unused_spad_addr = spad_addr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full      = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign empty     = (wr_q == rd_q);
    assign push      = req && !full;
    assign req_ready = !full;
    assign level     = wr_q - rd_q;
    assign head      = fifo_q[rd_q[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_q[PW-1:0]] <= '{spm: spm, we: req_we, addr: req_addr,
                                      saddr: spad_addr[SPAD_AW-1:0], wdata: req_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    if (!head.spm)    state_d = StMemWait;
                    else if (!head.we) state_d = StSramRd;
                end
            end
            StSramRd:  state_d = StIdle;
            StMemWait: if (mem_ack) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        sram_en     = 1'b0;
        sram_we     = 1'b0;
        mem_req     = 1'b0;
        pop         = 1'b0;
        rsp_load    = 1'b0;
        rsp_rdata_d = '0;
        rsp_hit_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty && head.spm) begin
                    sram_en   = 1'b1;
                    sram_we   = head.we;
                    pop       = 1'b1;
                    // Writes complete at this edge; reads respond from StSramRd.
                    rsp_load  = head.we;
                    rsp_hit_d = 1'b1;
                end
            end
            StSramRd: begin
                rsp_load    = 1'b1;
                rsp_rdata_d = sram_rdata;
                rsp_hit_d   = 1'b1;
            end
            StMemWait: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pop         = 1'b1;
                    rsp_load    = 1'b1;
                    rsp_rdata_d = head.we ? '0 : mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_hit_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_load;
            if (rsp_load) begin
                rsp_rdata_q <= rsp_rdata_d;
                rsp_hit_q   <= rsp_hit_d;
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_hit    = rsp_hit_q;

    assign sram_addr  = head.saddr;
    assign sram_wdata = head.wdata;
    assign mem_we     = head.we;
    assign mem_addr   = head.addr;
    assign mem_wdata  = head.wdata;

endmodule
